// File: rtl/rr_decode_arbiter8.sv
// 8-way round-robin arbiter with hold timeout; exports the granted client both as
// a 3-bit decoder select and as the matching one-hot enable.
module rr_decode_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit               TIMEOUT_EN  = (MAX_HOLD != 0);
    localparam int unsigned      HOLD_LAST_I = TIMEOUT_EN ? (MAX_HOLD - 1) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_LAST_I[HOLD_W-1:0];

    state_t            r_state, w_state_n;
    logic              r_valid, w_valid_n;
    logic [2:0]        r_idx, w_idx_n;
    logic [7:0]        r_gnt, w_gnt_n;
    logic              r_timeout, w_timeout_n;
    logic [2:0]        r_ptr, w_ptr_n;
    logic [HOLD_W-1:0] r_hold, w_hold_n;

    logic              w_found;
    logic [2:0]        w_pick;
    logic [2:0]        w_cand;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int unsigned i = 0; i < 8; i++) begin
            w_cand = r_ptr + 3'(i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_valid_n   = r_valid;
        w_idx_n     = r_idx;
        w_gnt_n     = r_gnt;
        w_timeout_n = 1'b0;
        w_ptr_n     = r_ptr;
        w_hold_n    = r_hold;

        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n = GRANT;
                    w_valid_n = 1'b1;
                    w_idx_n   = w_pick;
                    w_gnt_n   = 8'(8'd1 << w_pick);
                    w_hold_n  = '0;
                end
            end
            GRANT: begin
                if (r_hold != '1) begin
                    w_hold_n = r_hold + 1'b1;
                end
                // A normal release outranks a simultaneous timeout, which then stays silent.
                if (done[r_idx] || !req[r_idx] || (TIMEOUT_EN && (r_hold == HOLD_LAST))) begin
                    w_state_n   = IDLE;
                    w_valid_n   = 1'b0;
                    w_gnt_n     = '0;
                    w_ptr_n     = r_idx + 3'd1;
                    w_timeout_n = !(done[r_idx] || !req[r_idx]);
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_gnt     <= '0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_valid   <= w_valid_n;
            r_idx     <= w_idx_n;
            r_gnt     <= w_gnt_n;
            r_timeout <= w_timeout_n;
            r_ptr     <= w_ptr_n;
            r_hold    <= w_hold_n;
        end
    end

    assign gnt_valid = r_valid;
    assign gnt_idx   = r_idx;
    assign gnt       = r_gnt;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter8.sv
// Bench for rr_decode_arbiter8: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_rr_decode_arbiter8;

    localparam int unsigned MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] done = '0;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    rr_decode_arbiter8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx),
        .gnt      (gnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, how many cycles it has been visible, rotating pointer.
    int m_valid = 0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_cycles = 0;
    int m_to = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cycles = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_valid == 0) begin
                for (int i = 0; i < 8; i++) begin
                    if (req[(m_ptr + i) % 8]) begin
                        m_valid = 1;
                        m_idx = (m_ptr + i) % 8;
                        m_cycles = 1;
                        break;
                    end
                end
            end else if (done[m_idx] || !req[m_idx]) begin
                m_valid = 0;
                m_ptr = (m_idx + 1) % 8;
            end else if (MAX_HOLD != 0 && m_cycles == MAX_HOLD) begin
                m_valid = 0;
                m_ptr = (m_idx + 1) % 8;
                m_to = 1;
            end else begin
                m_cycles++;
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] exp_v;
        exp_v = {m_valid[0], m_idx[2:0], (m_valid != 0) ? 8'(1 << m_idx) : 8'h00, m_to[0]};
        chk("model{valid,idx,gnt,timeout}", {19'd0, gnt_valid, gnt_idx, gnt, timeout}, {19'd0, exp_v});
    end

    task automatic wait_grant(input int limit);
        for (int k = 0; k < limit && !gnt_valid; k++) @(negedge clk);
        chk("grant_within_bound", {31'd0, gnt_valid}, 32'd1);
    endtask

    initial begin
        int hi;
        int seen;
        logic [7:0] to_gnt;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", {19'd0, gnt_valid, gnt_idx, gnt, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_req_gnt", {24'd0, gnt}, 32'h00);
        end

        // Single request, release via done, then ptr=4 favours client 4 over 3.
        req = 8'h08;
        @(negedge clk);
        chk("single_gnt", {24'd0, gnt}, 32'h08);
        chk("single_idx", {29'd0, gnt_idx}, 32'd3);
        chk("single_valid", {31'd0, gnt_valid}, 32'd1);
        done = 8'h08;
        @(negedge clk);
        done = 8'h00;
        chk("single_release", {24'd0, gnt}, 32'h00);
        req = 8'h18;
        @(negedge clk);
        chk("ptr4_pick", {24'd0, gnt}, 32'h10);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // Timeout on client 0.
        req = 8'h01;
        hi = 0; seen = 0; to_gnt = 8'hFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt == 8'h01) hi++;
            if (timeout) begin
                seen = 1;
                to_gnt = gnt;
                break;
            end
        end
        chk("timeout_seen", seen, 1);
        chk("timeout_hold_cycles", hi, 16);
        chk("timeout_gnt_low", {24'd0, to_gnt}, 32'h00);
        @(negedge clk);
        chk("timeout_pulse_one_cycle", {31'd0, timeout}, 32'd0);
        chk("regrant_sole_client", {24'd0, gnt}, 32'h01);
        req = 8'h00;
        @(negedge clk);

        // Bring ptr back to 0 via client 7.
        req = 8'h80;
        wait_grant(4);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // Priority / ignore / done coinciding with timeout.
        req = 8'h81;
        @(negedge clk);
        chk("prio_gnt0", {24'd0, gnt}, 32'h01);
        done = 8'h80;
        @(negedge clk);
        done = 8'h00;
        chk("foreign_done_ignored", {24'd0, gnt}, 32'h01);
        repeat (14) @(negedge clk);
        chk("still_held_before_limit", {24'd0, gnt}, 32'h01);
        done = 8'h01;
        @(negedge clk);
        done = 8'h00;
        chk("done_at_limit_gnt", {24'd0, gnt}, 32'h00);
        chk("done_at_limit_no_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        chk("next_goes_to_7", {29'd0, gnt_idx}, 32'd7);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // Round robin with all clients requesting.
        req = 8'hFF;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            wait_grant(4);
            chk("rr_order", {29'd0, gnt_idx}, k % 8);
            @(negedge clk);
            done = gnt;
            @(negedge clk);
            done = 8'h00;
            chk("rr_idle_gap", {24'd0, gnt}, 32'h00);
            @(negedge clk);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Reset in the middle of a grant.
        req = 8'h20;
        wait_grant(4);
        chk("midgrant_idx5", {29'd0, gnt_idx}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_gnt", {23'd0, gnt_valid, gnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h21;
        @(negedge clk);
        chk("post_reset_ptr0", {24'd0, gnt}, 32'h01);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // Random traffic, checked by the model process.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 5) == 0) done = gnt | 8'($urandom);
            else done = 8'($urandom) & 8'($urandom) & 8'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h00;
        done = 8'h00;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
